ps2_cmd_sequencer: RTL and testbench
====================================

Name: ps2_cmd_sequencer

Overview:
- Sits between a command requester (CPU register block or boot logic) and the PS/2 bytestream engine.
- Transmits a PS/2 command byte plus an optional argument byte, waits for the device ACK, and retries on RESEND.
- Enforces a response timeout and reports a completion status.
- When no command is in flight, forwards all device-originated bytes (scan codes, mouse packets) to the receive consumer.

Parameters:
CLK_RATE, 50000000, clock frequency in Hz
TIMEOUT_MS, 20, ACK wait timeout in milliseconds; TIMEOUT_CYCLES = CLK_RATE/1000*TIMEOUT_MS
MAX_RETRIES, 3, RESEND responses tolerated per byte before failure

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cmd_valid  in  1  command request; held until cmd_ready
cmd_byte  in  8  command byte
cmd_has_arg  in  1  command carries an argument byte
cmd_arg  in  8  argument byte
cmd_ready  out  1  high in IDLE; cmd_valid&&cmd_ready accepts the request
done  out  1  one-cycle pulse when a command finishes
status  out  2  valid while done is high; 0 OK, 1 retries exhausted, 2 timeout, 3 device error (0xFC)
busy  out  1  command in flight
bs_tx_data  out  8  byte to bytestream engine
bs_tx_valid  out  1  bs_tx_data valid
bs_tx_consume  in  1  engine took the byte (one-cycle pulse)
bs_rx_data  in  8  byte from engine
bs_rx_produce  in  1  bs_rx_data valid (one-cycle pulse)
rx_data  out  8  forwarded device byte
rx_produce  out  1  one-cycle pulse, rx_data valid

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1; state IDLE; counters 0.
- The request is captured into registers on acceptance. Inputs are don't-care afterwards.
- States and transitions:
  - IDLE: accept request -> SEND_CMD, retry_cnt=0.
  - SEND_CMD / SEND_ARG: bs_tx_valid=1 with bs_tx_data stable. On bs_tx_consume -> WAIT_CMD / WAIT_ARG and load the timeout counter with TIMEOUT_CYCLES-1.
  - WAIT_x, on bs_rx_produce:
    - 0xFA: WAIT_CMD -> SEND_ARG if has_arg, else FINISH(OK); WAIT_ARG -> FINISH(OK); retry_cnt cleared.
    - 0xFE: if retry_cnt==MAX_RETRIES -> FINISH(1); else retry_cnt++ and return to the matching SEND_x.
    - 0xFC: FINISH(3).
    - Any other byte: forwarded on rx_data/rx_produce; state and timer unchanged.
  - WAIT_x, counter reaching 0 with no rx byte: FINISH(2).
  - FINISH: done=1 and status for exactly one cycle -> IDLE; cmd_ready returns high the following cycle.
- Forwarding: rx_produce/rx_data are registered, one cycle after bs_rx_produce. This applies in IDLE, SEND_x, FINISH, and to non-protocol bytes in WAIT_x. Protocol bytes (0xFA/0xFE/0xFC) consumed in WAIT_x are never forwarded.
- An rx byte in the same cycle as timer expiry: the byte is processed, the timeout is ignored.
- Request accepted in the same cycle as an rx byte arrives in IDLE: both are handled (byte forwarded, command starts).
- bs_tx_valid never deasserts before bs_tx_consume. A retry re-presents the identical byte.
- busy=1 in every state except IDLE.
- Timer width is $clog2(TIMEOUT_CYCLES). It saturates at 0 and is idle outside WAIT_x.
- retry_cnt width is $clog2(MAX_RETRIES+1).
- Reset mid-operation returns to IDLE immediately with no done pulse. The engine is expected to be reset by the same signal.

Optional Feature:
PS2_CMD_INIT_EN
- Defined: after reset, the block autonomously issues 0xFF (device reset) before entering IDLE.
  - Waits for ACK, then waits up to 1000 ms for 0xAA (BAT pass) using the same timer.
  - cmd_ready stays 0 throughout.
  - One done pulse is produced: status 0 on 0xAA; 2 on timeout; 3 on 0xFC, or on any other byte received in the BAT wait.
- Undefined: the block starts in IDLE with cmd_ready=1 and no automatic traffic.

Decomposition:
- Package ps2_cmd_pkg holds:
  - byte constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_ERROR=8'hFC, PS2_RESET=8'hFF, PS2_BAT_OK=8'hAA;
  - status codes ST_OK/ST_RETRY/ST_TIMEOUT/ST_DEVERR;
  - the state enumeration.
- One sub-module, ps2_timeout_ctr: load/enable/expired down-counter parameterised by cycle count.

Test Plan:
- cmd 0xF4 with no argument; engine consumes, then returns 0xFA -> one bs_tx byte 0xF4; done with status 0; no rx_produce.
- cmd 0xED with arg 0x07; ACK after each byte -> tx sequence 0xED, 0x07; done status 0 after the second ACK.
- cmd 0xF3; device replies 0xFE, 0xFE, 0xFA -> 0xF3 sent 3 times; status 0. Separately, 4×0xFE with MAX_RETRIES=3 -> 0xF3 sent 4 times; status 1.
- cmd 0xF2 with no response, TIMEOUT_MS reduced so TIMEOUT_CYCLES=100 -> done status 2 exactly 100 cycles after consume. A byte 0x1C injected during the wait -> rx_data 0x1C forwarded, status still 2 at the same cycle.
- IDLE rx bytes 0xF0, 0x1C -> rx_produce pulses 1 cycle after each, data matches. Assert reset mid-WAIT_ARG -> cmd_ready=1, busy=0, no done pulse.
- With PS2_CMD_INIT_EN: release reset; ACK 0xFA then 0xAA -> tx 0xFF, done status 0, then cmd_ready=1.

Source files
------------

// File: rtl/ps2_cmd_pkg.sv
// Shared constants, status codes and FSM states for the PS/2 command sequencer.
// Init states are only reachable when PS2_CMD_INIT_EN is defined.
package ps2_cmd_pkg;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERROR  = 8'hFC;
    localparam logic [7:0] PS2_RESET  = 8'hFF;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_RETRY   = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_DEVERR  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_CMD,
        S_WAIT_CMD,
        S_SEND_ARG,
        S_WAIT_ARG,
        S_FINISH,
        S_INIT_SEND,
        S_INIT_ACK,
        S_INIT_BAT
    } state_t;

    function automatic logic is_protocol(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ERROR);
    endfunction

endpackage

// File: rtl/ps2_timeout_ctr.sv
// Loadable down-counter that saturates at zero; expired is high while it reads zero.
module ps2_timeout_ctr #(
    parameter int CYCLES = 1000,
    parameter int WIDTH  = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 command sequencer: sends cmd (+arg), handles ACK/RESEND/ERROR, timeout, rx forwarding.
// Define PS2_CMD_INIT_EN to issue a device reset (0xFF) and await BAT after reset.
module ps2_cmd_sequencer
    import ps2_cmd_pkg::*;
#(
    parameter int CLK_RATE    = 50000000,
    parameter int TIMEOUT_MS  = 20,
    parameter int MAX_RETRIES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    output logic       cmd_ready,
    output logic       done,
    output logic [1:0] status,
    output logic       busy,
    output logic [7:0] bs_tx_data,
    output logic       bs_tx_valid,
    input  logic       bs_tx_consume,
    input  logic [7:0] bs_rx_data,
    input  logic       bs_rx_produce,
    output logic [7:0] rx_data,
    output logic       rx_produce
);

    localparam int TIMEOUT_CYCLES = CLK_RATE / 1000 * TIMEOUT_MS;
`ifdef PS2_CMD_INIT_EN
    localparam int BAT_CYCLES = CLK_RATE;
    localparam int TMR_SPAN = (BAT_CYCLES > TIMEOUT_CYCLES) ? BAT_CYCLES : TIMEOUT_CYCLES;
    localparam state_t RST_STATE = S_INIT_SEND;
`else
    localparam int TMR_SPAN = TIMEOUT_CYCLES;
    localparam state_t RST_STATE = S_IDLE;
`endif
    localparam int TW = (TMR_SPAN > 1) ? $clog2(TMR_SPAN) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    state_t          state, state_n;
    logic [7:0]      cmd_q, arg_q;
    logic            has_arg_q;
    logic [RW-1:0]   retry_cnt, retry_n;
    logic [1:0]      status_q, status_n;
    logic            tmr_load, tmr_en, tmr_expired;
    logic [TW-1:0]   tmr_val;
    logic            fwd;

    ps2_timeout_ctr #(
        .CYCLES (TMR_SPAN),
        .WIDTH  (TW)
    ) u_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RST_STATE;
            cmd_q      <= '0;
            arg_q      <= '0;
            has_arg_q  <= 1'b0;
            retry_cnt  <= '0;
            status_q   <= ST_OK;
            rx_data    <= '0;
            rx_produce <= 1'b0;
        end else begin
            state     <= state_n;
            retry_cnt <= retry_n;
            status_q  <= status_n;
            if (state == S_IDLE && cmd_valid) begin
                cmd_q     <= cmd_byte;
                arg_q     <= cmd_arg;
                has_arg_q <= cmd_has_arg;
            end
            rx_produce <= fwd;
            if (fwd) begin
                rx_data <= bs_rx_data;
            end
        end
    end

    always_comb begin
        state_n  = state;
        retry_n  = retry_cnt;
        status_n = status_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        fwd      = bs_rx_produce;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_n = S_SEND_CMD;
                    retry_n = '0;
                end
            end
            S_SEND_CMD, S_SEND_ARG, S_INIT_SEND: begin
                if (bs_tx_consume) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT_CYCLES - 1);
                    state_n  = (state == S_SEND_CMD) ? S_WAIT_CMD :
                               (state == S_SEND_ARG) ? S_WAIT_ARG : S_INIT_ACK;
                end
            end
            S_WAIT_CMD, S_WAIT_ARG, S_INIT_ACK: begin
                tmr_en = 1'b1;
                if (bs_rx_produce) begin
                    fwd = !is_protocol(bs_rx_data);
                    if (bs_rx_data == PS2_ACK) begin
                        retry_n  = '0;
                        state_n  = S_FINISH;
                        status_n = ST_OK;
                        if (state == S_WAIT_CMD && has_arg_q) begin
                            state_n = S_SEND_ARG;
                        end
`ifdef PS2_CMD_INIT_EN
                        if (state == S_INIT_ACK) begin
                            state_n  = S_INIT_BAT;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(BAT_CYCLES - 1);
                        end
`endif
                    end else if (bs_rx_data == PS2_RESEND) begin
                        if (retry_cnt == RW'(MAX_RETRIES)) begin
                            state_n  = S_FINISH;
                            status_n = ST_RETRY;
                        end else begin
                            retry_n = retry_cnt + 1'b1;
                            state_n = (state == S_WAIT_CMD) ? S_SEND_CMD :
                                      (state == S_WAIT_ARG) ? S_SEND_ARG : S_INIT_SEND;
                        end
                    end else if (bs_rx_data == PS2_ERROR) begin
                        state_n  = S_FINISH;
                        status_n = ST_DEVERR;
                    end
                end else if (tmr_expired) begin
                    state_n  = S_FINISH;
                    status_n = ST_TIMEOUT;
                end
            end
`ifdef PS2_CMD_INIT_EN
            S_INIT_BAT: begin
                tmr_en = 1'b1;
                if (bs_rx_produce) begin
                    // Anything other than BAT pass here means the device self-test failed.
                    fwd      = 1'b0;
                    state_n  = S_FINISH;
                    status_n = (bs_rx_data == PS2_BAT_OK) ? ST_OK : ST_DEVERR;
                end else if (tmr_expired) begin
                    state_n  = S_FINISH;
                    status_n = ST_TIMEOUT;
                end
            end
`endif
            S_FINISH: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bs_tx_valid = 1'b0;
        bs_tx_data  = '0;
        unique case (state)
            S_SEND_CMD: begin
                bs_tx_valid = 1'b1;
                bs_tx_data  = cmd_q;
            end
            S_SEND_ARG: begin
                bs_tx_valid = 1'b1;
                bs_tx_data  = arg_q;
            end
            S_INIT_SEND: begin
                bs_tx_valid = 1'b1;
                bs_tx_data  = PS2_RESET;
            end
            default: begin
                bs_tx_valid = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FINISH);
    assign status    = done ? status_q : ST_OK;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Bench for ps2_cmd_sequencer: directed table, corner sequences and random
// device-response scripts checked against a behavioural command/response model.
module tb_ps2_cmd_sequencer;
    import ps2_cmd_pkg::*;

    localparam int CLK_RATE    = 100000;
    localparam int TIMEOUT_MS  = 1;
    localparam int MAX_RETRIES = 3;
    localparam int TMO         = 100;
    localparam int NO_RESP     = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte = '0;
    logic       cmd_has_arg = 1'b0;
    logic [7:0] cmd_arg = '0;
    logic       cmd_ready, done, busy, bs_tx_valid, rx_produce;
    logic [1:0] status;
    logic [7:0] bs_tx_data, rx_data;
    logic       bs_tx_consume = 1'b0;
    logic [7:0] bs_rx_data = '0;
    logic       bs_rx_produce = 1'b0;

    always #5 clk = ~clk;

    ps2_cmd_sequencer #(
        .CLK_RATE    (CLK_RATE),
        .TIMEOUT_MS  (TIMEOUT_MS),
        .MAX_RETRIES (MAX_RETRIES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_byte      (cmd_byte),
        .cmd_has_arg   (cmd_has_arg),
        .cmd_arg       (cmd_arg),
        .cmd_ready     (cmd_ready),
        .done          (done),
        .status        (status),
        .busy          (busy),
        .bs_tx_data    (bs_tx_data),
        .bs_tx_valid   (bs_tx_valid),
        .bs_tx_consume (bs_tx_consume),
        .bs_rx_data    (bs_rx_data),
        .bs_rx_produce (bs_rx_produce),
        .rx_data       (rx_data),
        .rx_produce    (rx_produce)
    );

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [7:0] tx_log[$];
    logic [7:0] fwd_log[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_fwd[$];
    int resp_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_produce) fwd_log.push_back(rx_data);
            if (done) done_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic consume();
        bs_tx_consume = 1'b1;
        cyc();
        bs_tx_consume = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        bs_rx_data = b;
        bs_rx_produce = 1'b1;
        cyc();
        bs_rx_produce = 1'b0;
    endtask

    task automatic wait_tx();
        int g = 0;
        while (!bs_tx_valid && g < 50) begin
            cyc();
            g++;
        end
        check("tx_valid_bound", int'(bs_tx_valid), 1);
    endtask

    task automatic wait_done(output int st);
        int g = 0;
        while (!done && g < 400) begin
            cyc();
            g++;
        end
        check("done_bound", int'(done), 1);
        st = status;
        cyc();
    endtask

    function automatic bit is_prot(input int r);
        return r == 8'hFA || r == 8'hFE || r == 8'hFC;
    endfunction

    // Walks the response script byte by byte: which bytes go out, which are forwarded, final status.
    function automatic int model(input logic [7:0] c, input logic ha, input logic [7:0] a);
        logic [7:0] seq[$];
        int idx = 0, retries = 0, pos = 0, r, res = -1;
        exp_tx.delete();
        exp_fwd.delete();
        seq.push_back(c);
        if (ha) seq.push_back(a);
        while (res < 0) begin
            exp_tx.push_back(seq[idx]);
            r = -1;
            while (pos < resp_q.size()) begin
                r = resp_q[pos];
                pos++;
                if (r == NO_RESP || is_prot(r)) break;
                exp_fwd.push_back(8'(r));
                r = -1;
            end
            if (r == -1 || r == NO_RESP) res = 2;
            else if (r == 8'hFC) res = 3;
            else if (r == 8'hFE) begin
                if (retries == MAX_RETRIES) res = 1;
                else retries++;
            end else begin
                retries = 0;
                idx++;
                if (idx == seq.size()) res = 0;
            end
        end
        return res;
    endfunction

    task automatic run_cmd(input logic [7:0] c, input logic ha, input logic [7:0] a,
                           output int st, output int ndone);
        int pos = 0, g, d0;
        bit fin = 0;
        tx_log.delete();
        fwd_log.delete();
        d0 = done_cnt;
        st = -1;
        cmd_valid = 1'b1;
        cmd_byte = c;
        cmd_has_arg = ha;
        cmd_arg = a;
        g = 0;
        while (!cmd_ready && g < 50) begin
            cyc();
            g++;
        end
        cyc();
        cmd_valid = 1'b0;
        cmd_byte = 8'($urandom);
        cmd_arg = 8'($urandom);
        cmd_has_arg = 1'($urandom);
        while (!fin) begin
            g = 0;
            while (!done && !bs_tx_valid && g < 400) begin
                cyc();
                g++;
            end
            if (done) begin
                st = status;
                fin = 1;
            end else if (bs_tx_valid) begin
                tx_log.push_back(bs_tx_data);
                repeat ($urandom_range(0, 2)) cyc();
                consume();
                repeat ($urandom_range(1, 3)) cyc();
                while (pos < resp_q.size()) begin
                    int r = resp_q[pos];
                    pos++;
                    if (r == NO_RESP) break;
                    rx(r[7:0]);
                    if (is_prot(r)) break;
                    cyc();
                end
            end else begin
                check("cmd_activity_bound", 0, 1);
                fin = 1;
            end
        end
        cyc();
        cyc();
        ndone = done_cnt - d0;
    endtask

    typedef struct {
        logic [7:0] c;
        logic       ha;
        logic [7:0] a;
        int         resp[6];
        int         n;
        int         st;
        int         ntx;
        int         nfwd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int st, nd, n, k;
        logic [7:0] c, a;
        logic ha;

        tbl[0] = '{8'hF4, 1'b0, 8'h00, '{8'hFA, 0, 0, 0, 0, 0}, 1, 0, 1, 0};
        tbl[1] = '{8'hED, 1'b1, 8'h07, '{8'hFA, 8'hFA, 0, 0, 0, 0}, 2, 0, 2, 0};
        tbl[2] = '{8'hF3, 1'b0, 8'h00, '{8'hFE, 8'hFE, 8'hFA, 0, 0, 0}, 3, 0, 3, 0};
        tbl[3] = '{8'hF3, 1'b0, 8'h00, '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 0, 0}, 4, 1, 4, 0};
        tbl[4] = '{8'hF2, 1'b0, 8'h00, '{NO_RESP, 0, 0, 0, 0, 0}, 1, 2, 1, 0};
        tbl[5] = '{8'hF5, 1'b0, 8'h00, '{8'hFC, 0, 0, 0, 0, 0}, 1, 3, 1, 0};
        tbl[6] = '{8'hE8, 1'b1, 8'h02, '{8'hFA, 8'hFE, 8'hFA, 0, 0, 0}, 3, 0, 3, 0};
        tbl[7] = '{8'hF0, 1'b1, 8'h01, '{8'hFA, 8'hFC, 0, 0, 0, 0}, 2, 3, 2, 0};
        tbl[8] = '{8'hF2, 1'b0, 8'h00, '{8'h1C, 8'hFA, 0, 0, 0, 0}, 2, 0, 1, 1};
        tbl[9] = '{8'hF3, 1'b1, 8'h05, '{8'hFE, 8'hFA, 8'hFE, 8'hFE, 8'hFE, 8'hFE}, 6, 1, 6, 0};

        #2 reset = 1'b1;
        #20;
`ifdef PS2_CMD_INIT_EN
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_tx_data", int'(bs_tx_data), 8'hFF);
`else
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_tx_valid", int'(bs_tx_valid), 0);
        check("rst_tx_data", int'(bs_tx_data), 0);
`endif
        check("rst_done", int'(done), 0);
        check("rst_status", int'(status), 0);
        check("rst_rx_produce", int'(rx_produce), 0);
        check("rst_rx_data", int'(rx_data), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc();

`ifdef PS2_CMD_INIT_EN
        wait_tx();
        check("init_tx", int'(bs_tx_data), 8'hFF);
        check("init_ready_low", int'(cmd_ready), 0);
        consume();
        cyc();
        rx(8'hFA);
        cyc();
        check("init_ready_bat", int'(cmd_ready), 0);
        rx(8'hAA);
        wait_done(st);
        check("init_status", st, 0);
        check("init_ready_after", int'(cmd_ready), 1);
`endif

        // IDLE forwarding
        foreach (tbl[i]) begin end
        begin
            logic [7:0] ib[2];
            ib[0] = 8'hF0;
            ib[1] = 8'h1C;
            for (int i = 0; i < 2; i++) begin
                bs_rx_data = ib[i];
                bs_rx_produce = 1'b1;
                check("idle_fwd_pre", int'(rx_produce), 0);
                cyc();
                bs_rx_produce = 1'b0;
                check("idle_fwd_pulse", int'(rx_produce), 1);
                check("idle_fwd_data", int'(rx_data), int'(ib[i]));
                cyc();
                check("idle_fwd_end", int'(rx_produce), 0);
            end
        end

        // Directed table
        for (int i = 0; i < 10; i++) begin
            resp_q.delete();
            for (int j = 0; j < tbl[i].n; j++) resp_q.push_back(tbl[i].resp[j]);
            run_cmd(tbl[i].c, tbl[i].ha, tbl[i].a, st, nd);
            check($sformatf("tbl%0d_status", i), st, tbl[i].st);
            check($sformatf("tbl%0d_ndone", i), nd, 1);
            check($sformatf("tbl%0d_ntx", i), tx_log.size(), tbl[i].ntx);
            check($sformatf("tbl%0d_nfwd", i), fwd_log.size(), tbl[i].nfwd);
            if (tx_log.size() > 0)
                check($sformatf("tbl%0d_tx0", i), int'(tx_log[0]), int'(tbl[i].c));
        end

        // Exact timeout latency, without and with a non-protocol byte mid-wait
        for (int inj = 0; inj < 2; inj++) begin
            fwd_log.delete();
            cmd_valid = 1'b1;
            cmd_byte = 8'hF2;
            cmd_has_arg = 1'b0;
            cyc();
            cmd_valid = 1'b0;
            wait_tx();
            consume();
            n = 0;
            while (!done && n < 200) begin
                if (inj == 1 && n == 50) begin
                    bs_rx_data = 8'h1C;
                    bs_rx_produce = 1'b1;
                end
                cyc();
                bs_rx_produce = 1'b0;
                n++;
            end
            check($sformatf("tmo%0d_cycles", inj), n, TMO);
            check($sformatf("tmo%0d_status", inj), int'(status), 2);
            cyc();
            check($sformatf("tmo%0d_nfwd", inj), fwd_log.size(), inj);
            if (inj == 1 && fwd_log.size() > 0)
                check("tmo_fwd_data", int'(fwd_log[0]), 8'h1C);
        end

        // Accept and IDLE rx byte in the same cycle
        cmd_valid = 1'b1;
        cmd_byte = 8'hF4;
        cmd_has_arg = 1'b0;
        bs_rx_data = 8'h55;
        bs_rx_produce = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        bs_rx_produce = 1'b0;
        check("simul_fwd", int'(rx_produce), 1);
        check("simul_data", int'(rx_data), 8'h55);
        check("simul_busy", int'(busy), 1);
        wait_tx();
        check("simul_tx", int'(bs_tx_data), 8'hF4);
        consume();
        rx(8'hFA);
        wait_done(st);
        check("simul_status", st, 0);

        // Random response scripts against the model
        for (int it = 0; it < 25; it++) begin
            resp_q.delete();
            repeat (8) begin
                k = $urandom_range(0, 99);
                if (k < 55) resp_q.push_back(8'hFA);
                else if (k < 75) resp_q.push_back(8'hFE);
                else if (k < 80) resp_q.push_back(8'hFC);
                else if (k < 94) begin
                    n = $urandom_range(0, 255);
                    if (is_prot(n)) n = 8'h12;
                    resp_q.push_back(n);
                end else resp_q.push_back(NO_RESP);
            end
            c = 8'($urandom);
            a = 8'($urandom);
            ha = 1'($urandom);
            k = model(c, ha, a);
            run_cmd(c, ha, a, st, nd);
            check($sformatf("rnd%0d_status", it), st, k);
            check($sformatf("rnd%0d_ndone", it), nd, 1);
            check($sformatf("rnd%0d_ntx", it), tx_log.size(), exp_tx.size());
            check($sformatf("rnd%0d_nfwd", it), fwd_log.size(), exp_fwd.size());
            for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
                check($sformatf("rnd%0d_tx%0d", it, i), int'(tx_log[i]), int'(exp_tx[i]));
            for (int i = 0; i < fwd_log.size() && i < exp_fwd.size(); i++)
                check($sformatf("rnd%0d_fwd%0d", it, i), int'(fwd_log[i]), int'(exp_fwd[i]));
        end

        // Reset while waiting for the argument ACK
        cmd_valid = 1'b1;
        cmd_byte = 8'hED;
        cmd_has_arg = 1'b1;
        cmd_arg = 8'h07;
        cyc();
        cmd_valid = 1'b0;
        wait_tx();
        consume();
        rx(8'hFA);
        wait_tx();
        check("mid_arg_tx", int'(bs_tx_data), 8'h07);
        consume();
        cyc();
        k = done_cnt;
        reset = 1'b1;
        #1;
        check("mid_rst_done", int'(done), 0);
`ifdef PS2_CMD_INIT_EN
        check("mid_rst_init_tx", int'(bs_tx_valid), 1);
`else
        check("mid_rst_ready", int'(cmd_ready), 1);
        check("mid_rst_busy", int'(busy), 0);
`endif
        cyc();
        cyc();
        reset = 1'b0;
        repeat (5) cyc();
        check("mid_rst_no_done", done_cnt - k, 0);
`ifndef PS2_CMD_INIT_EN
        check("mid_rst_ready_after", int'(cmd_ready), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
